mskg4mul_sched: RTL

MSKG4MUL_SCHED -- requirements
Module: mskg4mul_sched

---
 rtl/mskg4mul_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mskg4mul_sched.sv
// Scheduler in front of a latency-1 masked GF(4) multiplier gadget: it arbitrates two requesters,
// pairs each issue with one fresh randomness word, and returns results in order through a 2-entry FIFO.
module mskg4mul_sched #(
    parameter int d = 2,
    localparam int RND = 2 * d * (d - 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [d-1:0]   req_a0_0,
    input  logic [d-1:0]   req_a1_0,
    input  logic [d-1:0]   req_b0_0,
    input  logic [d-1:0]   req_b1_0,
    input  logic [d-1:0]   req_a0_1,
    input  logic [d-1:0]   req_a1_1,
    input  logic [d-1:0]   req_b0_1,
    input  logic [d-1:0]   req_b1_1,
    input  logic           rnd_valid,
    output logic           rnd_ready,
    input  logic [RND-1:0] rnd_in,
    output logic [d-1:0]   g_ina0,
    output logic [d-1:0]   g_ina1,
    output logic [d-1:0]   g_inb0,
    output logic [d-1:0]   g_inb1,
    output logic [d-1:0]   g_ina0_prev,
    output logic [d-1:0]   g_ina1_prev,
    output logic [RND-1:0] g_rnd,
    input  logic [d-1:0]   g_out0,
    input  logic [d-1:0]   g_out1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_id,
    output logic [d-1:0]   out_c0,
    output logic [d-1:0]   out_c1
);

    // FIFO entry layout: {id, c1 shares, c0 shares}
    localparam int EW = 2 * d + 1;

    if (d < 2) begin : g_d_check
        $error("mskg4mul_sched: d must be at least 2");
    end

    logic           ptr_r;
    logic           s1_valid_r;
    logic           s1_id_r;
    logic [d-1:0]   ina0_prev_r;
    logic [d-1:0]   ina1_prev_r;
    logic [1:0]     fifo_count_r;
    logic [EW-1:0]  fifo_e0_r;
    logic [EW-1:0]  fifo_e1_r;

    logic           winner_s;
    logic           pop_s;
    logic [2:0]     occ_s;
    logic           issue_s;
    logic [1:0]     fifo_count_s;
    logic [EW-1:0]  fifo_e0_s;
    logic [EW-1:0]  fifo_e1_s;
    logic [EW-1:0]  push_data_s;

    // Round-robin pick: the pointer only matters when both requesters are valid
    always_comb begin
        winner_s = 1'b0;
        if (req_valid == 2'b11) begin
            winner_s = ptr_r;
        end else if (req_valid[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Results in flight after this cycle's pop must leave room for one more in the FIFO
    always_comb begin
        pop_s   = out_valid & out_ready;
        occ_s   = {1'b0, fifo_count_r} + {2'b00, s1_valid_r} - {2'b00, pop_s};
        issue_s = 1'b0;
        if (!rst && rnd_valid && (req_valid != 2'b00) && (occ_s <= 3'd1)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Handshakes and gadget operands; idle cycles feed the gadget all-zero operands and randomness
    always_comb begin
        req_ready = 2'b00;
        rnd_ready = 1'b0;
        g_ina0    = {d{1'b0}};
        g_ina1    = {d{1'b0}};
        g_inb0    = {d{1'b0}};
        g_inb1    = {d{1'b0}};
        g_rnd     = {RND{1'b0}};
        if (issue_s) begin
            rnd_ready = 1'b1;
            g_rnd     = rnd_in;
            case (winner_s)
                1'b0: begin
                    req_ready = 2'b01;
                    g_ina0    = req_a0_0;
                    g_ina1    = req_a1_0;
                    g_inb0    = req_b0_0;
                    g_inb1    = req_b1_0;
                end
                1'b1: begin
                    req_ready = 2'b10;
                    g_ina0    = req_a0_1;
                    g_ina1    = req_a1_1;
                    g_inb0    = req_b0_1;
                    g_inb1    = req_b1_1;
                end
                default: begin
                    req_ready = 2'b00;
                end
            endcase
        end else begin
            req_ready = 2'b00;
        end
    end

    // Gadget stage tracking, arbitration pointer and previous-cycle a operand
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= 1'b0;
            s1_valid_r  <= 1'b0;
            s1_id_r     <= 1'b0;
            ina0_prev_r <= {d{1'b0}};
            ina1_prev_r <= {d{1'b0}};
        end else begin
            s1_valid_r  <= issue_s;
            s1_id_r     <= issue_s & winner_s;
            ptr_r       <= issue_s ? ~ptr_r : ptr_r;
            ina0_prev_r <= g_ina0;
            ina1_prev_r <= g_ina1;
        end
    end

    assign g_ina0_prev = ina0_prev_r;
    assign g_ina1_prev = ina1_prev_r;

    // FIFO next state; vacated slots are zeroed so an empty head reads as zero
    always_comb begin
        push_data_s  = {s1_id_r, g_out1, g_out0};
        fifo_count_s = fifo_count_r;
        fifo_e0_s    = fifo_e0_r;
        fifo_e1_s    = fifo_e1_r;
        case ({s1_valid_r, pop_s})
            2'b11: begin
                if (fifo_count_r == 2'd2) begin
                    fifo_e0_s = fifo_e1_r;
                    fifo_e1_s = push_data_s;
                end else begin
                    fifo_e0_s = push_data_s;
                    fifo_e1_s = {EW{1'b0}};
                end
            end
            2'b10: begin
                if (fifo_count_r == 2'd0) begin
                    fifo_e0_s    = push_data_s;
                    fifo_count_s = 2'd1;
                end else if (fifo_count_r == 2'd1) begin
                    fifo_e1_s    = push_data_s;
                    fifo_count_s = 2'd2;
                end else begin
                    fifo_count_s = fifo_count_r;
                end
            end
            2'b01: begin
                fifo_e0_s    = fifo_e1_r;
                fifo_e1_s    = {EW{1'b0}};
                fifo_count_s = fifo_count_r - 2'd1;
            end
            default: begin
                fifo_count_s = fifo_count_r;
            end
        endcase
    end

    // Output FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count_r <= 2'd0;
            fifo_e0_r    <= {EW{1'b0}};
            fifo_e1_r    <= {EW{1'b0}};
        end else begin
            fifo_count_r <= fifo_count_s;
            fifo_e0_r    <= fifo_e0_s;
            fifo_e1_r    <= fifo_e1_s;
        end
    end

    // Result stream from the FIFO head, forced to zero when empty
    always_comb begin
        out_valid = (fifo_count_r != 2'd0);
        if (out_valid) begin
            out_id = fifo_e0_r[EW-1];
            out_c1 = fifo_e0_r[2*d-1:d];
            out_c0 = fifo_e0_r[d-1:0];
        end else begin
            out_id = 1'b0;
            out_c1 = {d{1'b0}};
            out_c0 = {d{1'b0}};
        end
    end

endmodule
